// File: rtl/fht_result_reader.sv
// Unloads the FHT result from the four Radix-4 RAM banks. Samples are read in
// natural order, n = 0..N-1, and sent downstream one word per beat on a
// valid/ready stream that carries the sample index and a last marker.
//
// Ports:
//   iCLK, iRESET        clock, synchronous active-high reset
//   iSTART              one-cycle pulse that starts an unload (ignored while busy or done)
//   oADDR_RD_0..3       read address; the same value goes to all four banks
//   iDATA_0..3          bank read data, valid RD_LAT cycles after the address
//   oDATA/oINDEX/oLAST  output beat: sample, natural index, index == N-1
//   oVALID/iREADY       stream handshake
//   oBUSY               unload in progress
//   oDONE               one-cycle pulse after the last beat is accepted
module fht_result_reader #(
  parameter int unsigned N        = 1024,
  parameter int unsigned D_BIT    = 16,
  parameter int unsigned A_BIT    = 8,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned BANK_REV = 1
) (
  input  logic                   iCLK,
  input  logic                   iRESET,
  input  logic                   iSTART,
  output logic [A_BIT-1:0]       oADDR_RD_0,
  output logic [A_BIT-1:0]       oADDR_RD_1,
  output logic [A_BIT-1:0]       oADDR_RD_2,
  output logic [A_BIT-1:0]       oADDR_RD_3,
  input  logic [D_BIT-1:0]       iDATA_0,
  input  logic [D_BIT-1:0]       iDATA_1,
  input  logic [D_BIT-1:0]       iDATA_2,
  input  logic [D_BIT-1:0]       iDATA_3,
  output logic [D_BIT-1:0]       oDATA,
  output logic [$clog2(N)-1:0]   oINDEX,
  output logic                   oVALID,
  input  logic                   iREADY,
  output logic                   oLAST,
  output logic                   oBUSY,
  output logic                   oDONE
);

  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned DEPTH = RD_LAT + 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned SW    = $clog2(2 * DEPTH + 1);

  typedef struct packed {
    logic [D_BIT-1:0] data;
    logic [IW-1:0]    index;
    logic             last;
  } beat_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    n_q, n_d;
  logic [A_BIT-1:0] addr_q, addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Read pipe: stage k holds the read whose address was presented k cycles ago.
  logic             pv_q [RD_LAT+1];
  logic             pv_d [RD_LAT+1];
  logic [1:0]       pb_q [RD_LAT+1];
  logic [1:0]       pb_d [RD_LAT+1];
  logic [IW-1:0]    pn_q [RD_LAT+1];
  logic [IW-1:0]    pn_d [RD_LAT+1];

  // Shift-register FIFO: entry 0 is the head and drives the outputs directly.
  beat_t            fifo_q [DEPTH];
  beat_t            fifo_d [DEPTH];
  logic             fv_q   [DEPTH];
  logic             fv_d   [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             pop_c;
  logic             wr_c;
  logic             issue_c;
  logic             credit_ok_c;
  logic [IW-1:0]    issue_n_c;
  logic [1:0]       quarter_c;
  logic [1:0]       bank_c;
  logic [SW-1:0]    in_flight_c;
  logic [CW-1:0]    wr_idx_c;
  logic [D_BIT-1:0] rd_data_c;
  beat_t            new_beat_c;

  // Next-state, issue, read pipe and FIFO update.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pv_d    = pv_q;
    pb_d    = pb_q;
    pn_d    = pn_q;
    fifo_d  = fifo_q;
    fv_d    = fv_q;
    cnt_d   = cnt_q;
    issue_c   = 1'b0;
    issue_n_c = '0;

    pop_c = fv_q[0] & iREADY;
    wr_c  = pv_q[RD_LAT];

    // A read may issue only if everything already owed to the FIFO, plus this
    // read, still fits once this cycle's pop has freed its slot.
    in_flight_c = '0;
    for (int i = 0; i <= int'(RD_LAT); i++) begin
      in_flight_c = in_flight_c + SW'(pv_q[i]);
    end
    credit_ok_c = (SW'(cnt_q) + in_flight_c - SW'(pop_c)) < SW'(DEPTH);

    unique case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          issue_c   = 1'b1;
          issue_n_c = '0;
          n_d       = IW'(1);
          busy_d    = 1'b1;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (credit_ok_c) begin
          issue_c   = 1'b1;
          issue_n_c = n_q;
          if (n_q == IW'(N - 1)) begin
            state_d = S_DRAIN;
          end else begin
            n_d = n_q + IW'(1);
          end
        end
      end
      S_DRAIN: begin
        // The last beat is the final entry in flight, so its acceptance ends the unload.
        if (pop_c && fifo_q[0].last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        n_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Quarter index selects the bank, low bits select the address.
    quarter_c = issue_n_c[IW-1 -: 2];
    bank_c    = (BANK_REV != 0) ? {quarter_c[0], quarter_c[1]} : quarter_c;
    if (issue_c) begin
      addr_d = issue_n_c[A_BIT-1:0];
    end

    pv_d[0] = issue_c;
    pb_d[0] = bank_c;
    pn_d[0] = issue_n_c;
    for (int i = 1; i <= int'(RD_LAT); i++) begin
      pv_d[i] = pv_q[i-1];
      pb_d[i] = pb_q[i-1];
      pn_d[i] = pn_q[i-1];
    end

    unique case (pb_q[RD_LAT])
      2'd0:    rd_data_c = iDATA_0;
      2'd1:    rd_data_c = iDATA_1;
      2'd2:    rd_data_c = iDATA_2;
      default: rd_data_c = iDATA_3;
    endcase
    new_beat_c.data  = rd_data_c;
    new_beat_c.index = pn_q[RD_LAT];
    new_beat_c.last  = (pn_q[RD_LAT] == IW'(N - 1));

    if (pop_c) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        fifo_d[i] = fifo_q[i+1];
        fv_d[i]   = fv_q[i+1];
      end
      fv_d[DEPTH-1] = 1'b0;
    end

    wr_idx_c = cnt_q - CW'(pop_c);
    if (wr_c) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (CW'(i) == wr_idx_c) begin
          fifo_d[i] = new_beat_c;
          fv_d[i]   = 1'b1;
        end
      end
    end
    cnt_d = cnt_q + CW'(wr_c) - CW'(pop_c);
  end

  // State and datapath registers.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i <= int'(RD_LAT); i++) begin
        pv_q[i] <= 1'b0;
        pb_q[i] <= '0;
        pn_q[i] <= '0;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_q[i] <= '0;
        fv_q[i]   <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      pb_q    <= pb_d;
      pn_q    <= pn_d;
      fifo_q  <= fifo_d;
      fv_q    <= fv_d;
    end
  end

  assign oADDR_RD_0 = addr_q;
  assign oADDR_RD_1 = addr_q;
  assign oADDR_RD_2 = addr_q;
  assign oADDR_RD_3 = addr_q;
  assign oDATA      = fifo_q[0].data;
  assign oINDEX     = fifo_q[0].index;
  assign oLAST      = fifo_q[0].last;
  assign oVALID     = fv_q[0];
  assign oBUSY      = busy_q;
  assign oDONE      = done_q;

endmodule

// File: tb/tb_fht_result_reader.sv
// Bench for fht_result_reader: two instances (BANK_REV=1 and BANK_REV=0) share
// control inputs; each has its own latency-accurate bank model. Expected beats
// come from the loader's placement rule evaluated arithmetically per index.
module tb_fht_result_reader;

  localparam int N      = 1024;
  localparam int DB     = 16;
  localparam int AB     = 8;
  localparam int IW     = 10;
  localparam int RD_LAT = 2;
  localparam int BUDGET = 20 * N;

  logic clk;
  logic rst;
  logic start;
  logic ready;

  logic [AB-1:0] addr_a [4];
  logic [AB-1:0] addr_b [4];
  logic [DB-1:0] data_a [4];
  logic [DB-1:0] data_b [4];
  logic [AB-1:0] dly_a  [4][RD_LAT];
  logic [AB-1:0] dly_b  [4][RD_LAT];
  logic [DB-1:0] mem    [4][256];

  logic [DB-1:0] odata_a, odata_b;
  logic [IW-1:0] oidx_a, oidx_b;
  logic ovalid_a, ovalid_b, olast_a, olast_b, obusy_a, obusy_b, odone_a, odone_b;

  int n_cmp = 0;
  int n_err = 0;
  bit neg   = 1'b0;

  fht_result_reader #(.N(N), .D_BIT(DB), .A_BIT(AB), .RD_LAT(RD_LAT), .BANK_REV(1)) dut_a (
    .iCLK(clk), .iRESET(rst), .iSTART(start),
    .oADDR_RD_0(addr_a[0]), .oADDR_RD_1(addr_a[1]), .oADDR_RD_2(addr_a[2]), .oADDR_RD_3(addr_a[3]),
    .iDATA_0(data_a[0]), .iDATA_1(data_a[1]), .iDATA_2(data_a[2]), .iDATA_3(data_a[3]),
    .oDATA(odata_a), .oINDEX(oidx_a), .oVALID(ovalid_a), .iREADY(ready),
    .oLAST(olast_a), .oBUSY(obusy_a), .oDONE(odone_a)
  );

  fht_result_reader #(.N(N), .D_BIT(DB), .A_BIT(AB), .RD_LAT(RD_LAT), .BANK_REV(0)) dut_b (
    .iCLK(clk), .iRESET(rst), .iSTART(start),
    .oADDR_RD_0(addr_b[0]), .oADDR_RD_1(addr_b[1]), .oADDR_RD_2(addr_b[2]), .oADDR_RD_3(addr_b[3]),
    .iDATA_0(data_b[0]), .iDATA_1(data_b[1]), .iDATA_2(data_b[2]), .iDATA_3(data_b[3]),
    .oDATA(odata_b), .oINDEX(oidx_b), .oVALID(ovalid_b), .iREADY(ready),
    .oLAST(olast_b), .oBUSY(obusy_b), .oDONE(odone_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank RAMs: data appears RD_LAT cycles after the address.
  always @(posedge clk) begin
    for (int x = 0; x < 4; x++) begin
      dly_a[x][0] <= addr_a[x];
      dly_b[x][0] <= addr_b[x];
      for (int k = 1; k < RD_LAT; k++) begin
        dly_a[x][k] <= dly_a[x][k-1];
        dly_b[x][k] <= dly_b[x][k-1];
      end
    end
  end

  always_comb begin
    for (int x = 0; x < 4; x++) begin
      data_a[x] = mem[x][dly_a[x][RD_LAT-1]];
      data_b[x] = mem[x][dly_b[x][RD_LAT-1]];
    end
  end

  // Sample i was loaded at bank {q[0],q[1]} (or q), address i mod 256.
  function automatic logic [DB-1:0] exp_word(input int idx, input bit rev);
    int q, a, bank;
    q    = idx / 256;
    a    = idx % 256;
    bank = rev ? (((q % 2) * 2) + (q / 2)) : q;
    if (neg && bank == 0 && a == 5) return 16'h8000;
    return DB'(bank * 1000 + a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One unload; called and returning at #1 after a rising edge.
  task automatic run_unload(input bit rnd, input int stall_at, input int restart_at, input int reset_at);
    int exp_idx, cyc, first_cyc, last_cyc, stall_left, rphase;
    bit stalled, restarted, finished, xfer, pv, pr, prst;
    logic [DB-1:0] pd;
    logic [IW-1:0] pi;
    exp_idx = 0; cyc = 0; first_cyc = -1; last_cyc = -1; stall_left = 0; rphase = 0;
    stalled = 0; restarted = 0; finished = 0; pv = 0; pr = 1; prst = 0; pd = '0; pi = '0;
    start = 1'b1;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!finished && cyc < BUDGET) begin
      @(negedge clk);
      if (cyc == 1 && rphase == 0) chk("busy_after_start", 32'(obusy_a), 1);
      if (first_cyc < 0 && ovalid_a) first_cyc = cyc;
      if (pv && !pr && !prst && rphase == 0) begin
        chk("hold_valid", 32'(ovalid_a), 1);
        chk("hold_data", 32'(odata_a), 32'(pd));
        chk("hold_index", 32'(oidx_a), 32'(pi));
      end
      if (rphase == 2) begin
        chk("rst_valid", 32'(ovalid_a), 0);
        chk("rst_busy", 32'(obusy_a), 0);
        chk("rst_done", 32'(odone_a), 0);
        finished = 1;
      end else begin
        chk("done_a", 32'(odone_a), 32'(last_cyc >= 0 && cyc == last_cyc + 1));
        chk("done_b", 32'(odone_b), 32'(last_cyc >= 0 && cyc == last_cyc + 1));
        xfer = ovalid_a && ready && rphase == 0;
        if (xfer) begin
          chk("index_a", 32'(oidx_a), exp_idx);
          chk("data_a", 32'(odata_a), 32'(exp_word(exp_idx, 1'b1)));
          chk("last_a", 32'(olast_a), 32'(exp_idx == N - 1));
          chk("valid_b", 32'(ovalid_b), 1);
          chk("index_b", 32'(oidx_b), exp_idx);
          chk("data_b", 32'(odata_b), 32'(exp_word(exp_idx, 1'b0)));
          chk("last_b", 32'(olast_b), 32'(exp_idx == N - 1));
          if (!neg) begin
            if (exp_idx == 256) begin chk("idx256_rev1", 32'(odata_a), 2000); chk("idx256_rev0", 32'(odata_b), 1000); end
            if (exp_idx == 512) begin chk("idx512_rev1", 32'(odata_a), 1000); chk("idx512_rev0", 32'(odata_b), 2000); end
            if (exp_idx == 768) chk("idx768_rev1", 32'(odata_a), 3000);
            if (exp_idx == 1023) chk("idx1023_rev1", 32'(odata_a), 3255);
          end else if (exp_idx == 5) begin
            chk("neg_idx5", 32'(odata_a), 32'h8000);
          end
          if (exp_idx == N - 1) last_cyc = cyc;
          exp_idx++;
        end
        if (last_cyc >= 0 && cyc == last_cyc + 1) begin
          chk("busy_in_done", 32'(obusy_a), 0);
          finished = 1;
        end
      end
      pv = ovalid_a; pr = ready; pd = odata_a; pi = oidx_a; prst = (rphase != 0);
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b0;
      if (rphase == 1) rphase = 2;
      if (!finished) begin
        if (rphase == 0 && reset_at >= 0 && exp_idx == reset_at) begin rst = 1'b1; rphase = 1; end
        if (!restarted && restart_at >= 0 && exp_idx == restart_at) begin start = 1'b1; restarted = 1; end
        if (!stalled && stall_at >= 0 && exp_idx == stall_at) begin stalled = 1; stall_left = 20; end
        if (stall_left > 0) begin
          ready = 1'b0;
          stall_left--;
        end else begin
          ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        cyc++;
      end
    end
    chk("no_timeout", 32'(finished), 1);
    ready = 1'b1;
    if (reset_at < 0) begin
      chk("beat_count", exp_idx, N);
      if (!rnd) begin
        chk("first_valid_latency", first_cyc, RD_LAT + 2);
        chk("burst_span", last_cyc - first_cyc, N - 1);
      end
      @(negedge clk);
      chk("done_pulse_end", 32'(odone_a), 0);
      chk("idle_busy", 32'(obusy_a), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++)
        mem[b][a] = DB'(b * 1000 + a);
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(ovalid_a), 0);
    chk("reset_busy", 32'(obusy_a), 0);
    chk("reset_done", 32'(odone_a), 0);
    chk("reset_last", 32'(olast_a), 0);
    chk("reset_data", 32'(odata_a), 0);
    chk("reset_index", 32'(oidx_a), 0);
    chk("reset_addr", 32'(addr_a[0]), 0);
    @(posedge clk); #1;

    // Full-rate unload.
    run_unload(1'b0, -1, -1, -1);

    // Negative sample, random backpressure and a long stall at index 300.
    neg = 1'b1;
    mem[0][5] = 16'h8000;
    run_unload(1'b1, 300, -1, -1);

    // Extra iSTART while busy must be ignored.
    run_unload(1'b1, -1, 100, -1);

    // Reset mid-unload aborts with no oDONE.
    run_unload(1'b1, -1, -1, 400);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(odone_a), 0);
      chk("abort_idle_valid", 32'(ovalid_a), 0);
      @(posedge clk); #1;
    end

    // Unload again from index 0 after the abort.
    run_unload(1'b0, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fht_result_reader.md
Name: fht_result_reader

Overview:
- Unloads the FHT result from the four Radix-4 RAM banks after the transform completes.
- Reads the banks in natural sample order and streams one signed word per beat over a valid/ready interface, with a sample index and a last marker.
- It is the read-side counterpart of the ADC loader, which writes bank {i[0],i[1]} at address j for sample i*BANK_SIZE+j.
- Sits between fht_top's read ports (iADDR_RD_x/oDATA_x) and downstream consumers (spectrum logic, UART dump).

Parameters:
- N, 1024, transform length in points; power of 4.
- D_BIT, 16, bank word width (signed, includes bit expansion).
- A_BIT, 8, bank address width; must equal log2(N/4).
- RD_LAT, 2, bank read latency in cycles, from address to data; range 1..3.
- BANK_REV, 1: bank select = bit-reversed 2-bit quarter index. 0: bank select = quarter index directly.

Ports:
- iCLK  in  1  clock; also clocks the RAM read ports.
- iRESET  in  1  synchronous, active-high reset.
- iSTART  in  1  single-cycle pulse that starts an unload; tie to a registered oRDY edge of fht_top.
- oADDR_RD_0..3  out  A_BIT each  read address, identical value driven to all four banks.
- iDATA_0..3  in  D_BIT each  bank read data, valid RD_LAT cycles after the address.
- oDATA  out  D_BIT  output sample.
- oINDEX  out  log2(N)  natural-order index of oDATA.
- oVALID  out  1  oDATA/oINDEX/oLAST are valid.
- iREADY  in  1  consumer accepts the beat.
- oLAST  out  1  beat carries index N-1.
- oBUSY  out  1  unload in progress.
- oDONE  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; counters 0; output FIFO emptied; in-flight reads discarded.
- Reset mid-unload aborts the unload immediately. No oDONE is produced.
- Index mapping, for issue counter n in 0..N-1:
  - q = n[log2N-1 : log2N-2]; addr = n[A_BIT-1:0].
  - bank = BANK_REV ? {q[0],q[1]} : q.
  - oADDR_RD_x = addr.
  - bank and n travel through an RD_LAT-deep shift register alongside a valid bit.
  - At the pipe output, the selected iDATA_bank is written into the FIFO with its n.
- FIFO: depth RD_LAT+2; holds {data, index, last}.
- Credit rule: a read issues only if (FIFO count + in-flight reads) < RD_LAT+2. No data is ever dropped, whatever iREADY does.
- Output handshake:
  - oVALID = FIFO not empty; the head drives oDATA/oINDEX/oLAST.
  - A beat transfers when oVALID && iREADY.
  - While oVALID=1 and iREADY=0, outputs hold stable.
  - A simultaneous FIFO write and read in one cycle is legal; count stays unchanged.
- FSM:
  - IDLE: oBUSY=0. iSTART=1 -> READ, n=0, oBUSY=1 next cycle.
  - READ: issue one read per cycle while credit allows. After issuing n=N-1 -> DRAIN.
  - DRAIN: no new reads. When the pipe is empty, the FIFO is empty, and the final beat (oLAST) has been accepted -> DONE.
  - DONE: oDONE=1 for exactly one cycle; oBUSY=0 -> IDLE.
- iSTART while oBUSY=1 is ignored. iSTART in the DONE cycle is also ignored.
- Latency and throughput:
  - With iREADY held 1, the first oVALID appears RD_LAT+2 cycles after iSTART (1 cycle to READ, RD_LAT to data, 1 cycle for the FIFO register).
  - Throughput is 1 beat/cycle; N beats in N consecutive cycles.
  - oDONE asserts the cycle after the beat with index N-1 transfers.
- Address wrap: n counts 0..N-1 only and does not wrap. Addr wraps 255->0 at each quarter boundary.
- oADDR_RD_x holds its last value when not issuing; the value is don't-care for correctness.
- Data is passed through unmodified, sign preserved. No arithmetic on samples.

Test Plan:
- Bank model prefilled with word = bank*1000 + addr; BANK_REV=1; iREADY=1; pulse iSTART.
  - Stream beats: idx0=0, idx255=255, idx256=2000, idx512=1000, idx768=3000, idx1023=3255.
  - oLAST only on idx1023; oDONE 1 cycle after it.
  - N consecutive beats; first oVALID RD_LAT+2 cycles after iSTART.
- Same fill with BANK_REV=0 -> idx256=1000, idx512=2000.
- Random iREADY (50%) plus a 20-cycle iREADY=0 stall at idx 300:
  - All 1024 beats arrive in order with no duplicates or losses.
  - Outputs are stable during the stall; in-flight count never exceeds RD_LAT+2.
- Negative data: bank0 addr5 = -32768 -> idx5 oDATA=16'h8000.
- Second iSTART at idx 100 while busy -> ignored; exactly 1024 beats and one oDONE.
- iRESET asserted at idx 400 for 1 cycle -> next cycle oVALID=0, oBUSY=0, no oDONE.
  - A subsequent iSTART streams from idx0 again, 1024 beats.
